// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates per-core icache/dcache word requests onto one shared single-port RAM.
// Data requests beat instruction requests, round-robin within a class, grants held for up to BURST_MAX words.
// Define MEMCTL_STATS_EN to build per-core completed-word counters on stat_words.
module mem_arbiter_ctrl #(
    parameter int CPUS      = 2,
    parameter int BURST_MAX = 2
) (
    input  logic                CLK,
    input  logic                n_rst,
    input  logic [CPUS-1:0]     iREN,
    input  logic [32*CPUS-1:0]  iaddr,
    output logic [CPUS-1:0]     iwait,
    output logic [32*CPUS-1:0]  iload,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  logic [32*CPUS-1:0]  daddr,
    input  logic [32*CPUS-1:0]  dstore,
    output logic [CPUS-1:0]     dwait,
    output logic [32*CPUS-1:0]  dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    input  logic [31:0]         ramload,
    input  logic [1:0]          ramstate,
    output logic                memerr,
    output logic [32*CPUS-1:0]  stat_words
);
    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1_BAD1;

    typedef enum logic {IDLE, SERVE} state_t;

    state_t           state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_core;
    logic             owner_is_d;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;

    logic [CPUS-1:0]  d_req;
    logic             any_d;
    logic             any_i;
    logic [IDX_W-1:0] d_win;
    logic [IDX_W-1:0] i_win;
    int               search_idx;
    int               owner_base;

    logic o_dren, o_dwen, o_iren, o_active;
    logic serving, complete, is_err;
    logic [31:0] word;

    assign d_req = dREN | dWEN;
    assign any_d = |d_req;
    assign any_i = |iREN;

    // Scan from the slot after last_core; the lowest offset wins because it is visited last.
    always_comb begin
        d_win = '0;
        i_win = '0;
        search_idx = 0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            search_idx = (int'(last_core) + 1 + k) % CPUS;
            if (d_req[search_idx]) d_win = IDX_W'(search_idx);
            if (iREN[search_idx]) i_win = IDX_W'(search_idx);
        end
    end

    assign owner_base = 32 * int'(owner);
    assign o_dren     = dREN[owner];
    assign o_dwen     = dWEN[owner];
    assign o_iren     = iREN[owner];
    assign o_active   = owner_is_d ? (o_dren | o_dwen) : o_iren;
    assign serving    = (state == SERVE) && o_active;
    assign is_err     = (ramstate == RAM_ERROR);
    assign complete   = serving && ((ramstate == RAM_ACCESS) || is_err);
    assign word       = is_err ? ERR_WORD : ramload;
    assign cnt_inc    = burst_cnt + CNT_W'(1);

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (serving) begin
            if (owner_is_d) begin
                ramWEN   = o_dwen;
                ramREN   = o_dren & ~o_dwen;
                ramaddr  = daddr[owner_base +: 32];
                ramstore = dstore[owner_base +: 32];
            end else begin
                ramREN  = 1'b1;
                ramaddr = iaddr[owner_base +: 32];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CPUS; gi++) begin : g_port
            logic own_done;
            assign own_done = complete && (owner == IDX_W'(gi));
            assign dwait[gi] = ~(own_done & owner_is_d);
            assign iwait[gi] = ~(own_done & ~owner_is_d);
            assign dload[32*gi +: 32] = (own_done && owner_is_d && !o_dwen) ? word : '0;
            assign iload[32*gi +: 32] = (own_done && !owner_is_d) ? word : '0;
        end
    endgenerate

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            owner      <= '0;
            owner_is_d <= 1'b0;
            last_core  <= IDX_W'(CPUS - 1);
            burst_cnt  <= '0;
            memerr     <= 1'b0;
        end else begin
            if (complete && is_err) memerr <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_d || any_i) begin
                        owner      <= any_d ? d_win : i_win;
                        last_core  <= any_d ? d_win : i_win;
                        owner_is_d <= any_d;
                        burst_cnt  <= '0;
                        state      <= SERVE;
                    end
                end
                SERVE: begin
                    if (complete) begin
                        burst_cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(BURST_MAX)) state <= IDLE;
                    end else if (!o_active) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMCTL_STATS_EN
    generate
        for (genvar gi = 0; gi < CPUS; gi++) begin : g_stat
            logic [31:0] words_reg;
            always_ff @(posedge CLK or negedge n_rst) begin
                if (!n_rst) begin
                    words_reg <= '0;
                end else if (complete && (owner == IDX_W'(gi))) begin
                    words_reg <= words_reg + 32'd1;
                end
            end
            assign stat_words[32*gi +: 32] = words_reg;
        end
    endgenerate
`else
    assign stat_words = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: directed vector table, hand sequences, then random traffic against a memory scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter_ctrl;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        n_rst;
    logic [1:0]  iREN, dREN, dWEN, iwait, dwait;
    logic [63:0] iaddr, daddr, dstore, iload, dload, stat_words;
    logic        ramREN, ramWEN, memerr;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int failures = 0;
    int exp_stat [2];

    always #5 CLK = ~CLK;

    mem_arbiter_ctrl #(.CPUS(2), .BURST_MAX(2)) dut (
        .CLK(CLK), .n_rst(n_rst),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr), .stat_words(stat_words)
    );

    // RAM: either driven directly by the bench or by a small latency model
    logic        model_on;
    logic [1:0]  rs_drv;
    logic [31:0] rl_drv;
    logic [31:0] ram_mem [16];
    int          rcnt, rlat;
    logic [1:0]  model_rs;

    function automatic logic [31:0] init_val(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    always_comb begin
        model_rs = FREE;
        if (ramREN || ramWEN) model_rs = (rcnt >= rlat) ? ACC : BUSY;
    end
    assign ramstate = model_on ? model_rs : rs_drv;
    assign ramload  = model_on ? ram_mem[ramaddr[5:2]] : rl_drv;

    always @(posedge CLK) begin
        if (!model_on) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_val(i);
            rcnt <= 0;
            rlat <= 0;
        end else if (ramREN || ramWEN) begin
            if (model_rs == ACC) begin
                if (ramWEN) ram_mem[ramaddr[5:2]] <= ramstore;
                rcnt <= 0;
                rlat <= int'($urandom_range(0, 2));
            end else begin
                rcnt <= rcnt + 1;
            end
        end else begin
            rcnt <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string name);
`ifdef MEMCTL_STATS_EN
        chk(name, stat_words, {32'(exp_stat[1]), 32'(exp_stat[0])});
`else
        chk(name, stat_words, 64'd0);
`endif
    endtask

    typedef struct packed {
        logic [1:0]  iren, dren, dwen, rs;
        logic [31:0] rl;
        logic [1:0]  e_iwait, e_dwait;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic [63:0] e_iload, e_dload;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] iren, dren, dwen, rs, input logic [31:0] rl,
                                input logic [1:0] iw, dw, input logic ren, wen,
                                input logic [31:0] addr, store, input logic [63:0] il, dl,
                                input logic err);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.rl = rl;
        v.e_iwait = iw; v.e_dwait = dw; v.e_ren = ren; v.e_wen = wen;
        v.e_addr = addr; v.e_store = store; v.e_iload = il; v.e_dload = dl; v.e_err = err;
        return v;
    endfunction

    vec_t vecs [14];

    // Random-phase requester records and reference memory
    logic        d_act [2], d_wr [2], d_ren_too [2], i_act [2];
    logic [3:0]  d_idx [2], i_idx [2];
    logic [31:0] d_data [2];
    int          d_age [2], i_age [2];
    logic [31:0] ref_mem [16];

    task automatic drive_rand();
        for (int c = 0; c < 2; c++) begin
            dWEN[c] = d_act[c] && d_wr[c];
            dREN[c] = d_act[c] && (!d_wr[c] || d_ren_too[c]);
            daddr[32*c +: 32]  = {26'd0, d_idx[c], 2'b00};
            dstore[32*c +: 32] = d_data[c];
            iREN[c] = i_act[c];
            iaddr[32*c +: 32]  = {26'd0, i_idx[c], 2'b00};
        end
    endtask

    initial begin
        int order [6];
        int got;
        int lows;
        logic stuck;

        n_rst = 1'b0;
        model_on = 1'b0; rs_drv = FREE; rl_drv = '0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = {32'h200, 32'h100};
        daddr = {32'h80, 32'h40};
        dstore = {32'h1111_2222, 32'h3333_4444};
        exp_stat[0] = 0; exp_stat[1] = 0;

        // Reset state
        #12;
        chk("rst_iwait", 64'(iwait), 64'h3);
        chk("rst_dwait", 64'(dwait), 64'h3);
        chk("rst_ren_wen", 64'({ramREN, ramWEN}), 64'h0);
        chk("rst_addr", 64'(ramaddr), 64'h0);
        chk("rst_memerr", 64'(memerr), 64'h0);
        chk("rst_stats", stat_words, 64'h0);
        @(negedge CLK);
        n_rst = 1'b1;

        //          iren   dren   dwen   rs    rl            iw     dw     ren   wen   addr    store          iload                 dload                 err
        vecs[0]  = mk(2'b00, 2'b01, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[1]  = mk(2'b00, 2'b01, 2'b00, BUSY, 32'h0,        2'b11, 2'b11, 1'b1, 1'b0, 32'h40,  32'h3333_4444, 64'h0,                64'h0,                1'b0);
        vecs[2]  = mk(2'b00, 2'b01, 2'b00, ACC,  32'hCAFEF00D, 2'b11, 2'b10, 1'b1, 1'b0, 32'h40,  32'h3333_4444, 64'h0,                64'h0000_0000_CAFEF00D, 1'b0);
        vecs[3]  = mk(2'b00, 2'b00, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[4]  = mk(2'b01, 2'b00, 2'b10, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[5]  = mk(2'b01, 2'b00, 2'b10, ACC,  32'hDEAD,     2'b11, 2'b01, 1'b0, 1'b1, 32'h80,  32'h1111_2222, 64'h0,                64'h0,                1'b0);
        vecs[6]  = mk(2'b01, 2'b00, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[7]  = mk(2'b01, 2'b00, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[8]  = mk(2'b01, 2'b00, 2'b00, ACC,  32'h12345678, 2'b10, 2'b11, 1'b1, 1'b0, 32'h100, 32'h0,         64'h0000_0000_12345678, 64'h0,              1'b0);
        vecs[9]  = mk(2'b00, 2'b00, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[10] = mk(2'b00, 2'b01, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b0);
        vecs[11] = mk(2'b00, 2'b01, 2'b00, ERR,  32'h55,       2'b11, 2'b10, 1'b1, 1'b0, 32'h40,  32'h3333_4444, 64'h0,                64'h0000_0000_BAD1BAD1, 1'b0);
        vecs[12] = mk(2'b00, 2'b00, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b1);
        vecs[13] = mk(2'b00, 2'b00, 2'b00, FREE, 32'h0,        2'b11, 2'b11, 1'b0, 1'b0, 32'h0,   32'h0,         64'h0,                64'h0,                1'b1);

        for (int v = 0; v < 14; v++) begin
            @(posedge CLK); #1;
            iREN = vecs[v].iren; dREN = vecs[v].dren; dWEN = vecs[v].dwen;
            rs_drv = vecs[v].rs; rl_drv = vecs[v].rl;
            @(negedge CLK);
            chk($sformatf("vec%0d_iwait", v), 64'(iwait), 64'(vecs[v].e_iwait));
            chk($sformatf("vec%0d_dwait", v), 64'(dwait), 64'(vecs[v].e_dwait));
            chk($sformatf("vec%0d_ren_wen", v), 64'({ramREN, ramWEN}), 64'({vecs[v].e_ren, vecs[v].e_wen}));
            chk($sformatf("vec%0d_addr", v), 64'(ramaddr), 64'(vecs[v].e_addr));
            chk($sformatf("vec%0d_store", v), 64'(ramstore), 64'(vecs[v].e_store));
            chk($sformatf("vec%0d_iload", v), iload, vecs[v].e_iload);
            chk($sformatf("vec%0d_dload", v), dload, vecs[v].e_dload);
            chk($sformatf("vec%0d_memerr", v), 64'(memerr), 64'(vecs[v].e_err));
            for (int c = 0; c < 2; c++)
                if (!vecs[v].e_iwait[c] || !vecs[v].e_dwait[c]) exp_stat[c]++;
            $display("vec %0d applied iREN=%b dREN=%b dWEN=%b ramstate=%0d", v, vecs[v].iren, vecs[v].dren, vecs[v].dwen, vecs[v].rs);
        end
        @(posedge CLK); #1;
        chk_stats("table_stats");

        // Reset while serving: outputs drop asynchronously, sticky error and counters clear
        dREN = 2'b01; rs_drv = BUSY;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("mid_ren_before", 64'(ramREN), 64'h1);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_rst_dwait", 64'(dwait), 64'h3);
        chk("mid_rst_iwait", 64'(iwait), 64'h3);
        chk("mid_rst_enables", 64'({ramREN, ramWEN}), 64'h0);
        chk("mid_rst_memerr", 64'(memerr), 64'h0);
        exp_stat[0] = 0; exp_stat[1] = 0;
        chk_stats("mid_rst_stats");
        $display("reset asserted mid-burst");
        dREN = 2'b00; rs_drv = FREE;
        @(negedge CLK);
        n_rst = 1'b1;

        // Round-robin: both cores hold dREN with instant RAM -> 0,0,1,1,0,0
        @(posedge CLK); #1;
        dREN = 2'b11; rs_drv = ACC; rl_drv = 32'h0BAD_F00D;
        got = 0;
        for (int cyc = 0; cyc < 24 && got < 6; cyc++) begin
            @(negedge CLK);
            if (dwait != 2'b11) begin
                order[got] = (dwait == 2'b10) ? 0 : (dwait == 2'b01) ? 1 : 9;
                $display("rr word %0d to core%0d", got, order[got]);
                got++;
            end
        end
        chk("rr_count", 64'(got), 64'd6);
        chk("rr_w0", 64'(order[0]), 64'd0);
        chk("rr_w1", 64'(order[1]), 64'd0);
        chk("rr_w2", 64'(order[2]), 64'd1);
        chk("rr_w3", 64'(order[3]), 64'd1);
        chk("rr_w4", 64'(order[4]), 64'd0);
        chk("rr_w5", 64'(order[5]), 64'd0);
        exp_stat[0] += 4; exp_stat[1] += 2;
        @(posedge CLK); #1;
        dREN = 2'b00;

        // Burst hold: core1 fills 0x80/0x84 back-to-back while core0 waits
        @(posedge CLK); #1;
        dREN = 2'b11;
        @(negedge CLK);
        chk("burst_idle_dwait", 64'(dwait), 64'h3);
        @(negedge CLK);
        chk("burst_w1_dwait", 64'(dwait), 64'h1);
        chk("burst_w1_addr", 64'(ramaddr), 64'h80);
        @(posedge CLK); #1;
        daddr[63:32] = 32'h84;
        @(negedge CLK);
        chk("burst_w2_dwait", 64'(dwait), 64'h1);
        chk("burst_w2_addr", 64'(ramaddr), 64'h84);
        @(posedge CLK); #1;
        dREN = 2'b01;
        @(negedge CLK);
        chk("burst_gap_dwait", 64'(dwait), 64'h3);
        chk("burst_gap_ren", 64'(ramREN), 64'h0);
        @(negedge CLK);
        chk("burst_core0_dwait", 64'(dwait), 64'h2);
        chk("burst_core0_addr", 64'(ramaddr), 64'h40);
        $display("burst hold sequence done");
        exp_stat[1] += 2; exp_stat[0] += 1;
        @(posedge CLK); #1;
        dREN = 2'b00; daddr[63:32] = 32'h80; rs_drv = FREE;
        @(posedge CLK); #1;
        chk_stats("directed_stats");

        // Random traffic against the reference memory
        model_on = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        for (int c = 0; c < 2; c++) begin
            d_act[c] = 1'b0; i_act[c] = 1'b0; d_wr[c] = 1'b0; d_ren_too[c] = 1'b0;
            d_idx[c] = '0; i_idx[c] = '0; d_data[c] = '0; d_age[c] = 0; i_age[c] = 0;
        end
        stuck = 1'b0;
        for (int cyc = 0; cyc < 3000 && !stuck; cyc++) begin
            @(posedge CLK); #1;
            for (int c = 0; c < 2; c++) begin
                if (!d_act[c] && $urandom_range(0, 7) == 0) begin
                    d_act[c] = 1'b1; d_wr[c] = $urandom_range(0, 1) == 1;
                    d_ren_too[c] = $urandom_range(0, 1) == 1;
                    d_idx[c] = 4'($urandom_range(0, 15)); d_data[c] = $urandom; d_age[c] = 0;
                end
                if (!i_act[c] && $urandom_range(0, 3) == 0) begin
                    i_act[c] = 1'b1; i_idx[c] = 4'($urandom_range(0, 15)); i_age[c] = 0;
                end
            end
            drive_rand();
            @(negedge CLK);
            lows = 0;
            for (int c = 0; c < 2; c++) lows += int'(!dwait[c]) + int'(!iwait[c]);
            chk("one_completion", 64'(lows <= 1), 64'h1);
            for (int c = 0; c < 2; c++) begin
                if (!dwait[c]) begin
                    chk("rand_d_expected", 64'(d_act[c]), 64'h1);
                    chk("rand_d_addr", 64'(ramaddr), 64'({26'd0, d_idx[c], 2'b00}));
                    if (d_wr[c]) begin
                        chk("rand_d_wen", 64'({ramWEN, ramREN}), 64'h2);
                        chk("rand_d_store", 64'(ramstore), 64'(d_data[c]));
                        ref_mem[d_idx[c]] = d_data[c];
                        $display("txn core%0d D wr addr=%h data=%h", c, {d_idx[c], 2'b00}, d_data[c]);
                    end else begin
                        chk("rand_d_load", 64'(dload[32*c +: 32]), 64'(ref_mem[d_idx[c]]));
                        $display("txn core%0d D rd addr=%h data=%h", c, {d_idx[c], 2'b00}, dload[32*c +: 32]);
                    end
                    d_act[c] = 1'b0; exp_stat[c]++;
                end else begin
                    chk("rand_d_idle_load", 64'(dload[32*c +: 32]), 64'h0);
                    if (d_act[c]) d_age[c]++;
                end
                if (!iwait[c]) begin
                    chk("rand_i_expected", 64'(i_act[c]), 64'h1);
                    chk("rand_i_load", 64'(iload[32*c +: 32]), 64'(ref_mem[i_idx[c]]));
                    $display("txn core%0d I rd addr=%h data=%h", c, {i_idx[c], 2'b00}, iload[32*c +: 32]);
                    i_act[c] = 1'b0; exp_stat[c]++;
                end else begin
                    chk("rand_i_idle_load", 64'(iload[32*c +: 32]), 64'h0);
                    if (i_act[c]) i_age[c]++;
                end
                if (d_age[c] > 400 || i_age[c] > 400) begin
                    stuck = 1'b1;
                    failures++;
                    $display("FAIL rand_timeout: core%0d request pending d_age=%0d i_age=%0d limit 400", c, d_age[c], i_age[c]);
                end
            end
        end
        @(posedge CLK); #1;
        for (int c = 0; c < 2; c++) begin d_act[c] = 1'b0; i_act[c] = 1'b0; end
        drive_rand();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk_stats("random_stats");
        chk("final_memerr", 64'(memerr), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
